// File: rtl/alu_mon_pkg.sv
// alu_mon_pkg: shared types and the golden ALU model for the result monitor.
package alu_mon_pkg;

    // Operand/result width the golden model and mismatch record are built for
    localparam int MON_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_SHL  = 4'b0100,
        OP_SHR  = 4'b0101,
        OP_ROL  = 4'b0110,
        OP_ROR  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_NOR  = 4'b1011,
        OP_NAND = 4'b1100,
        OP_XNOR = 4'b1101,
        OP_GT   = 4'b1110,
        OP_EQU  = 4'b1111
    } alu_op_e;

    // One queued mismatch; the reader recomputes the expected result itself
    typedef struct packed {
        logic [3:0]       sel;
        logic [MON_W-1:0] a;
        logic [MON_W-1:0] b;
        logic [MON_W-1:0] out;
        logic             carry;
        logic             exp_carry;
    } mis_rec_t;

    // Returns {carry, result}; carry is always the unsigned add carry-out.
    // Division by zero yields 0 here, but such samples are never compared.
    function automatic logic [MON_W:0] alu_golden(input logic [MON_W-1:0] a,
                                                  input logic [MON_W-1:0] b,
                                                  input logic [3:0]       sel);
        logic [MON_W:0]   sum;
        logic [MON_W-1:0] res;
        sum = {1'b0, a} + {1'b0, b};
        res = '0;
        case (alu_op_e'(sel))
            OP_ADD:  res = sum[MON_W-1:0];
            OP_SUB:  res = a - b;
            OP_MUL:  res = a * b;
            OP_DIV:  res = (b == '0) ? '0 : a / b;
            OP_SHL:  res = a << 1;
            OP_SHR:  res = a >> 1;
            OP_ROL:  res = {a[MON_W-2:0], a[MON_W-1]};
            OP_ROR:  res = {a[0], a[MON_W-1:1]};
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            OP_XNOR: res = ~(a ^ b);
            OP_GT:   res = {{(MON_W-1){1'b0}}, (a > b)};
            OP_EQU:  res = {{(MON_W-1){1'b0}}, (a == b)};
            default: res = '0;
        endcase
        return {sum[MON_W], res};
    endfunction

endpackage

// File: rtl/alu_mon_fifo.sv
// alu_mon_fifo: first-word-fall-through synchronous FIFO holding mismatch records.
// A push while full is only accepted when a pop frees the head in the same cycle.
module alu_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB tells a full ring from an empty one
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        data_o  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer update; clear empties the queue without touching storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Record storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/alu_result_monitor.sv
// alu_result_monitor: samples the ALU pins on a strobe, compares them one cycle
// later with the golden model, keeps saturating counters and queues mismatches.
module alu_result_monitor
    import alu_mon_pkg::*;
#(
    parameter int W     = MON_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             smp_valid,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [3:0]       ALU_Sel,
    input  logic [W-1:0]     ALU_Out,
    input  logic             CarryOut,
    output logic             mis_valid,
    input  logic             mis_ready,
    output logic [3*W+5:0]   mis_data,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             any_fail,
    output logic             fifo_ovf
);

    logic             v1_q;
    logic [W-1:0]     a_q, b_q, out_q;
    logic [3:0]       sel_q;
    logic             carry_q;

    logic [W:0]       golden;
    logic             is_skip, is_match, hit_pass, hit_fail, hit_skip;
    logic             fifo_full, fifo_empty, fifo_pop, drop;
    mis_rec_t         rec;

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             any_fail_q, any_fail_d;
    logic             fifo_ovf_q, fifo_ovf_d;

    // Stage 1: capture the pins on the strobe; clear discards a same-cycle sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else if (clear) begin
            v1_q    <= 1'b0;
        end else begin
            v1_q <= smp_valid;
            if (smp_valid) begin
                a_q     <= A;
                b_q     <= B;
                sel_q   <= ALU_Sel;
                out_q   <= ALU_Out;
                carry_q <= CarryOut;
            end
        end
    end

    // Stage 2: classify the captured sample and build its mismatch record
    always_comb begin
        golden   = alu_golden(a_q, b_q, sel_q);
        is_skip  = (alu_op_e'(sel_q) == OP_DIV) && (b_q == '0);
        is_match = (out_q == golden[W-1:0]) && (carry_q == golden[W]);
        hit_skip = v1_q && is_skip;
        hit_pass = v1_q && !is_skip && is_match;
        hit_fail = v1_q && !is_skip && !is_match;
        fifo_pop = !fifo_empty && mis_ready;
        drop     = hit_fail && fifo_full && !fifo_pop;
        rec      = '{sel: sel_q, a: a_q, b: b_q, out: out_q,
                     carry: carry_q, exp_carry: golden[W]};
    end

    // Saturating counters and sticky flags, next-state
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (hit_pass && pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
        if (hit_fail && fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        if (hit_skip && skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + 1'b1;
        any_fail_d = any_fail_q | hit_fail;
        fifo_ovf_d = fifo_ovf_q | drop;
    end

    // Counter and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            skip_cnt_q <= '0;
            any_fail_q <= 1'b0;
            fifo_ovf_q <= 1'b0;
        end else if (clear) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            skip_cnt_q <= '0;
            any_fail_q <= 1'b0;
            fifo_ovf_q <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            skip_cnt_q <= skip_cnt_d;
            any_fail_q <= any_fail_d;
            fifo_ovf_q <= fifo_ovf_d;
        end
    end

    alu_mon_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(mis_rec_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push_i  (hit_fail),
        .data_i  (rec),
        .pop_i   (fifo_pop),
        .data_o  (mis_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign mis_valid = !fifo_empty;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign skip_cnt  = skip_cnt_q;
    assign any_fail  = any_fail_q;
    assign fifo_ovf  = fifo_ovf_q;

endmodule

// File: tb/tb_alu_result_monitor.sv
// tb_alu_result_monitor: scenario tasks against an arithmetic reference model
// with a queue standing in for the mismatch FIFO.
module tb_alu_result_monitor;

    localparam int W     = 8;
    localparam int CNT_W = 16;
    localparam int RW    = 3*W + 6;
    localparam int QMAX  = 4;

    logic             clk = 1'b0;
    logic             rst, clear, smp_valid, mis_ready, CarryOut;
    logic [W-1:0]     A, B, ALU_Out;
    logic [3:0]       ALU_Sel;
    logic             mis_valid, any_fail, fifo_ovf;
    logic [RW-1:0]    mis_data;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, skip_cnt;

    int checks = 0;
    int passed = 0;

    int            mPass, mFail, mSkip;
    bit            mAnyFail, mOvf;
    logic [RW-1:0] mQ[$];

    always #5 clk = ~clk;

    alu_result_monitor #(.W(W), .DEPTH(QMAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .smp_valid(smp_valid),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
        .mis_valid(mis_valid), .mis_ready(mis_ready), .mis_data(mis_data),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
        .any_fail(any_fail), .fifo_ovf(fifo_ovf)
    );

    // Reference ALU from plain integer arithmetic: {carry, result}
    function automatic logic [8:0] refAlu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        case (sel)
            4'd0:    r = (ia + ib) % 256;
            4'd1:    r = (ia - ib + 256) % 256;
            4'd2:    r = (ia * ib) % 256;
            4'd3:    r = (ib == 0) ? 0 : ia / ib;
            4'd4:    r = (ia * 2) % 256;
            4'd5:    r = ia / 2;
            4'd6:    r = (ia * 2) % 256 + ia / 128;
            4'd7:    r = ia / 2 + (ia % 2) * 128;
            4'd8:    r = int'(a & b);
            4'd9:    r = int'(a | b);
            4'd10:   r = int'(a ^ b);
            4'd11:   r = 255 - int'(a | b);
            4'd12:   r = 255 - int'(a & b);
            4'd13:   r = 255 - int'(a ^ b);
            4'd14:   r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        return {((ia + ib) > 255), 8'(r)};
    endfunction

    function automatic logic [3*CNT_W+1:0] expStatus();
        int p, f, s;
        p = (mPass > 65535) ? 65535 : mPass;
        f = (mFail > 65535) ? 65535 : mFail;
        s = (mSkip > 65535) ? 65535 : mSkip;
        return {16'(p), 16'(f), 16'(s), mAnyFail, mOvf};
    endfunction

    task automatic modelReset();
        mPass = 0; mFail = 0; mSkip = 0;
        mAnyFail = 1'b0; mOvf = 1'b0;
        mQ.delete();
    endtask

    // Model of one sample while nobody drains the queue
    task automatic modelSample(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sel, input logic [7:0] out, input logic co);
        logic [8:0] e;
        e = refAlu(a, b, sel);
        if (sel == 4'd3 && b == 8'd0) mSkip++;
        else if (out == e[7:0] && co == e[8]) mPass++;
        else begin
            mFail++;
            mAnyFail = 1'b1;
            if (mQ.size() < QMAX) mQ.push_back({sel, a, b, out, co, e[8]});
            else mOvf = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] sel, input logic [7:0] out, input logic co);
        A = a; B = b; ALU_Sel = sel; ALU_Out = out; CarryOut = co;
        smp_valid = 1'b1;
        modelSample(a, b, sel, out, co);
        @(negedge clk);
    endtask

    task automatic driveGood(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [8:0] e;
        e = refAlu(a, b, sel);
        applyStimulus(a, b, sel, e[7:0], e[8]);
    endtask

    task automatic driveBad(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [8:0] e;
        logic [7:0] bb;
        bb = (sel == 4'd3 && b == 8'd0) ? 8'd1 : b;
        e  = refAlu(a, bb, sel);
        if ($urandom_range(1) == 0) applyStimulus(a, bb, sel, e[7:0] ^ 8'(1 << $urandom_range(7)), e[8]);
        else applyStimulus(a, bb, sel, e[7:0], ~e[8]);
    endtask

    task automatic idle(input int n);
        smp_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clearDut();
        smp_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== '0) $display("[TB] FAIL reset_status: got %h want 0", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf});
        else passed++;
        checks++;
        if (mis_valid !== 1'b0) $display("[TB] FAIL reset_mis_valid: got %b want 0", mis_valid);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pass();
        clearDut();
        driveGood(8'h0F, 8'h03, 4'b0010);
        smp_valid = 1'b0;
        checks++;
        if (pass_cnt !== 16'd0) $display("[TB] FAIL single_pass_early: got %0d want 0", pass_cnt);
        else passed++;
        @(negedge clk);
        checks++;
        if ({pass_cnt, fail_cnt, mis_valid} !== {16'd1, 16'd0, 1'b0}) $display("[TB] FAIL single_pass: got pass=%0d fail=%0d mv=%b want 1 0 0", pass_cnt, fail_cnt, mis_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clearDut();
        driveGood(8'hAA, 8'h55, 4'b0010);
        driveGood(8'hAA, 8'h55, 4'b1000);
        driveGood(8'hAA, 8'h55, 4'b1101);
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== expStatus()) $display("[TB] FAIL back_to_back: got %h want %h", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf}, expStatus());
        else passed++;
    endtask

    task automatic test_mismatch_record();
        clearDut();
        applyStimulus(8'h55, 8'h55, 4'b1101, 8'h00, 1'b0);
        idle(1);
        checks++;
        if ({fail_cnt, any_fail, mis_valid} !== {16'd1, 1'b1, 1'b1}) $display("[TB] FAIL mismatch_flags: got fail=%0d af=%b mv=%b want 1 1 1", fail_cnt, any_fail, mis_valid);
        else passed++;
        checks++;
        if (mis_data !== {4'hD, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0}) $display("[TB] FAIL mismatch_record: got %h want %h", mis_data, {4'hD, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0});
        else passed++;
        mis_ready = 1'b1;
        @(negedge clk);
        mis_ready = 1'b0;
        checks++;
        if (mis_valid !== 1'b0) $display("[TB] FAIL mismatch_popped: got mv=%b want 0", mis_valid);
        else passed++;
    endtask

    task automatic test_overflow();
        clearDut();
        for (int i = 0; i < 6; i++) driveBad(8'($urandom), 8'($urandom), 4'($urandom));
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== expStatus()) $display("[TB] FAIL overflow_status: got %h want %h", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf}, expStatus());
        else passed++;
        for (int i = 0; i < QMAX; i++) begin
            checks++;
            if (mis_valid !== 1'b1 || mis_data !== mQ[i]) $display("[TB] FAIL overflow_drain%0d: got mv=%b %h want 1 %h", i, mis_valid, mis_data, mQ[i]);
            else passed++;
            mis_ready = 1'b1;
            @(negedge clk);
            mis_ready = 1'b0;
        end
        checks++;
        if (mis_valid !== 1'b0) $display("[TB] FAIL overflow_empty: got mv=%b want 0", mis_valid);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] a;
        logic [8:0] e;
        clearDut();
        for (int i = 0; i < QMAX; i++) driveBad(8'($urandom), 8'($urandom), 4'b1010);
        idle(3);
        a = 8'($urandom);
        e = refAlu(a, 8'h3C, 4'b0000);
        A = a; B = 8'h3C; ALU_Sel = 4'b0000; ALU_Out = ~e[7:0]; CarryOut = e[8];
        smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        mis_ready = 1'b1;
        @(negedge clk);
        mis_ready = 1'b0;
        void'(mQ.pop_front());
        mQ.push_back({4'b0000, a, 8'h3C, ~e[7:0], e[8], e[8]});
        mFail++;
        mAnyFail = 1'b1;
        @(negedge clk);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== expStatus()) $display("[TB] FAIL full_push_pop_status: got %h want %h", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf}, expStatus());
        else passed++;
        for (int i = 0; i < QMAX; i++) begin
            checks++;
            if (mis_valid !== 1'b1 || mis_data !== mQ[i]) $display("[TB] FAIL full_push_pop_drain%0d: got mv=%b %h want 1 %h", i, mis_valid, mis_data, mQ[i]);
            else passed++;
            mis_ready = 1'b1;
            @(negedge clk);
            mis_ready = 1'b0;
        end
    endtask

    task automatic test_empty_push_pop();
        logic [8:0] e;
        clearDut();
        mis_ready = 1'b1;
        e = refAlu(8'h81, 8'h90, 4'b0000);
        A = 8'h81; B = 8'h90; ALU_Sel = 4'b0000; ALU_Out = e[7:0]; CarryOut = ~e[8];
        smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mis_valid !== 1'b1 || mis_data !== {4'b0000, 8'h81, 8'h90, e[7:0], ~e[8], e[8]}) $display("[TB] FAIL empty_push_pop_stored: got mv=%b %h want 1 %h", mis_valid, mis_data, {4'b0000, 8'h81, 8'h90, e[7:0], ~e[8], e[8]});
        else passed++;
        @(negedge clk);
        mis_ready = 1'b0;
        checks++;
        if (mis_valid !== 1'b0) $display("[TB] FAIL empty_push_pop_drained: got mv=%b want 0", mis_valid);
        else passed++;
    endtask

    task automatic test_div_zero();
        clearDut();
        applyStimulus(8'($urandom), 8'h00, 4'b0011, 8'($urandom), 1'($urandom));
        driveGood(8'hC8, 8'h07, 4'b0011);
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== {16'd1, 16'd0, 16'd1, 1'b0, 1'b0}) $display("[TB] FAIL div_zero: got %h want skip=1 pass=1", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf});
        else passed++;
    endtask

    task automatic test_random();
        int drained;
        clearDut();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(9) < 7) driveGood(8'($urandom), 8'($urandom_range(3) == 0 ? 0 : $urandom), 4'($urandom));
            else driveBad(8'($urandom), 8'($urandom), 4'($urandom));
            if ($urandom_range(3) == 0) idle(1);
        end
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== expStatus()) $display("[TB] FAIL random_status: got %h want %h", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf}, expStatus());
        else passed++;
        drained = mQ.size();
        for (int i = 0; i < drained; i++) begin
            checks++;
            if (mis_valid !== 1'b1 || mis_data !== mQ[i]) $display("[TB] FAIL random_drain%0d: got mv=%b %h want 1 %h", i, mis_valid, mis_data, mQ[i]);
            else passed++;
            mis_ready = 1'b1;
            @(negedge clk);
            mis_ready = 1'b0;
        end
        checks++;
        if (mis_valid !== 1'b0) $display("[TB] FAIL random_empty: got mv=%b want 0", mis_valid);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        clearDut();
        driveBad(8'h12, 8'h34, 4'b0000);
        A = 8'h56; B = 8'h78; ALU_Sel = 4'b1000; ALU_Out = 8'hFF;
        rst = 1'b1;
        @(negedge clk);
        A = 8'h9A; ALU_Sel = 4'b1001;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf, mis_valid} !== '0) $display("[TB] FAIL reset_midstream: got %h want 0", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf, mis_valid});
        else passed++;
        clear = 1'b1;
        A = 8'h01; B = 8'h01; ALU_Sel = 4'b0000; ALU_Out = 8'h00; CarryOut = 1'b1;
        smp_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        driveBad(8'h44, 8'h22, 4'b0001);
        smp_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelReset();
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf, mis_valid} !== '0) $display("[TB] FAIL clear_wins: got %h want 0", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf, mis_valid});
        else passed++;
    endtask

    task automatic test_saturation();
        clearDut();
        A = 8'h00; B = 8'h00; ALU_Sel = 4'b0000; ALU_Out = 8'h00; CarryOut = 1'b0;
        smp_valid = 1'b1;
        repeat (65540) @(negedge clk);
        mPass = 65540;
        idle(3);
        checks++;
        if ({pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf} !== expStatus()) $display("[TB] FAIL saturation: got %h want %h", {pass_cnt, fail_cnt, skip_cnt, any_fail, fifo_ovf}, expStatus());
        else passed++;
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1; clear = 1'b0; smp_valid = 1'b0; mis_ready = 1'b0;
        A = '0; B = '0; ALU_Sel = '0; ALU_Out = '0; CarryOut = 1'b0;
        modelReset();
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_mismatch_record();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_div_zero();
        test_random();
        test_reset_midstream();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
